// File: rtl/ex_alu_md_pkg.sv
// Opcode and mult/div FSM encodings shared by the EX ALU, its mult/div unit and the control decoder.
package ex_alu_md_pkg;

    typedef enum logic [4:0] {
        OP_ADD   = 5'h00,
        OP_SUB   = 5'h01,
        OP_AND   = 5'h02,
        OP_OR    = 5'h03,
        OP_NOR   = 5'h04,
        OP_XOR   = 5'h05,
        OP_SLT   = 5'h06,
        OP_SLTU  = 5'h07,
        OP_SLL   = 5'h08,
        OP_SRL   = 5'h09,
        OP_SRA   = 5'h0A,
        OP_SLLV  = 5'h0B,
        OP_SRLV  = 5'h0C,
        OP_SRAV  = 5'h0D,
        OP_LUI   = 5'h0E,
        OP_MFHI  = 5'h0F,
        OP_MFLO  = 5'h10,
        OP_MTHI  = 5'h11,
        OP_MTLO  = 5'h12,
        OP_MULT  = 5'h13,
        OP_MULTU = 5'h14,
        OP_DIV   = 5'h15,
        OP_DIVU  = 5'h16
    } alu_op_e;

    typedef enum logic [1:0] {
        MD_IDLE = 2'd0,
        MD_RUN  = 2'd1,
        MD_DONE = 2'd2
    } md_state_e;

    // Ops that start the iterative multiply/divide engine.
    function automatic logic is_md(input logic [4:0] op);
        return (op >= OP_MULT) && (op <= OP_DIVU);
    endfunction

    // Every op that touches HI/LO and must wait while the engine is busy.
    function automatic logic is_hilo(input logic [4:0] op);
        return (op >= OP_MFHI) && (op <= OP_DIVU);
    endfunction

endpackage

// File: rtl/ex_alu_md_if.sv
// EX-stage operand/result bundle between the pipeline (master) and the ALU (slave).
interface ex_alu_md_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
);
    logic               Ex_valid;
    logic               Ex_flush;
    logic [WIDTH-1:0]   A;
    logic [WIDTH-1:0]   B;
    logic [4:0]         Ex_ALUctr;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   Ex_ALUout;
    logic               Ex_Zero;
    logic               Ex_Sign;
    logic               Ex_Overflow;
    logic               md_busy;
    logic               md_done;
    logic               md_stall;

    modport master (
        output Ex_valid, Ex_flush, A, B, Ex_ALUctr, shamt,
        input  Ex_ALUout, Ex_Zero, Ex_Sign, Ex_Overflow, md_busy, md_done, md_stall
    );

    modport slave (
        input  Ex_valid, Ex_flush, A, B, Ex_ALUctr, shamt,
        output Ex_ALUout, Ex_Zero, Ex_Sign, Ex_Overflow, md_busy, md_done, md_stall
    );
endinterface

// File: rtl/ex_muldiv_seq.sv
// Iterative mult/div owning HI/LO: issue, WIDTH RUN cycles, DONE writes HI/LO (result visible WIDTH+2).
// No internal queueing: MD ops arriving while busy are ignored; the top raises md_stall to hold them.
module ex_muldiv_seq
    import ex_alu_md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid,
    input  logic             flush,
    input  logic [4:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    md_state_e            state, state_nxt;
    logic [SHAMT_W-1:0]   cnt;
    logic [WIDTH-1:0]     acc, q, m, a_raw;
    logic                 op_div, neg_q, neg_r, b_zero;
    logic                 issue, hl_wr;

    logic                 sgn_op, sa, sb;
    logic [WIDTH-1:0]     abs_a, abs_b;
    logic [WIDTH:0]       mul_sum, div_diff;
    logic [WIDTH-1:0]     div_rest;
    logic [2*WIDTH-1:0]   prod, prod_s;
    logic [WIDTH-1:0]     quo_s, rem_s;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= MD_IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = (state != MD_IDLE);
        done      = 1'b0;
        issue     = 1'b0;
        hl_wr     = 1'b0;
        case (state)
            MD_IDLE: begin
                if (valid && !flush && is_md(op)) begin
                    issue     = 1'b1;
                    state_nxt = MD_RUN;
                end
            end
            MD_RUN: begin
                if (flush)            state_nxt = MD_IDLE;
                else if (cnt == '0)   state_nxt = MD_DONE;
            end
            MD_DONE: begin
                state_nxt = MD_IDLE;
                if (!flush) begin
                    done  = 1'b1;
                    hl_wr = 1'b1;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
    end

    // Engine works on magnitudes; signs are reapplied in DONE.
    always_comb begin
        sgn_op   = (op == OP_MULT) || (op == OP_DIV);
        sa       = sgn_op & a[WIDTH-1];
        sb       = sgn_op & b[WIDTH-1];
        abs_a    = sa ? -a : a;
        abs_b    = sb ? -b : b;
        mul_sum  = {1'b0, acc} + (q[0] ? {1'b0, m} : '0);
        div_diff = {acc, q[WIDTH-1]} - {1'b0, m};
        div_rest = {acc[WIDTH-2:0], q[WIDTH-1]};
        prod     = {acc, q};
        prod_s   = neg_q ? -prod : prod;
        quo_s    = neg_q ? -q : q;
        rem_s    = neg_r ? -acc : acc;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            q      <= '0;
            m      <= '0;
            a_raw  <= '0;
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            b_zero <= 1'b0;
        end else begin
            if (issue) begin
                acc    <= '0;
                q      <= abs_a;
                m      <= abs_b;
                a_raw  <= a;
                cnt    <= SHAMT_W'(WIDTH - 1);
                op_div <= (op == OP_DIV) || (op == OP_DIVU);
                neg_q  <= sa ^ sb;
                neg_r  <= sa;
                b_zero <= (b == '0);
            end else if (state == MD_RUN && !flush) begin
                cnt <= cnt - 1'b1;
                if (op_div) begin
                    // Restoring step: a set borrow bit means the trial subtract failed.
                    acc <= div_diff[WIDTH] ? div_rest : div_diff[WIDTH-1:0];
                    q   <= {q[WIDTH-2:0], ~div_diff[WIDTH]};
                end else begin
                    {acc, q} <= {mul_sum, q[WIDTH-1:1]};
                end
            end

            if (hl_wr) begin
                if (!op_div) begin
                    {hi, lo} <= prod_s;
                end else if (b_zero) begin
                    hi <= a_raw;
                    lo <= '1;
                end else begin
                    hi <= rem_s;
                    lo <= quo_s;
                end
            end else if (valid && !flush && !busy) begin
                if (op == OP_MTHI) hi <= a;
                if (op == OP_MTLO) lo <= a;
            end
        end
    end

endmodule

// File: rtl/ex_alu_md.sv
// EX-stage ALU: combinational result/flags plus the HI/LO mult/div unit; result same cycle.
// md_stall holds any HI/LO-class op in EX while a mult/div is in flight.
module ex_alu_md
    import ex_alu_md_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic        clk,
    input  logic        rst_n,
    ex_alu_md_if.slave  ex
);

    logic [WIDTH-1:0] a, b, res, sum, diff, hi, lo;
    logic             ovf, busy;

    assign a = ex.A;
    assign b = ex.B;

    ex_muldiv_seq #(
        .WIDTH   (WIDTH),
        .SHAMT_W (SHAMT_W)
    ) u_muldiv (
        .clk   (clk),
        .rst_n (rst_n),
        .valid (ex.Ex_valid),
        .flush (ex.Ex_flush),
        .op    (ex.Ex_ALUctr),
        .a     (a),
        .b     (b),
        .hi    (hi),
        .lo    (lo),
        .busy  (busy),
        .done  (ex.md_done)
    );

    always_comb begin
        sum  = a + b;
        diff = a - b;
        res  = '0;
        ovf  = 1'b0;
        case (ex.Ex_ALUctr)
            OP_ADD: begin
                res = sum;
                ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                res = diff;
                ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  res = a & b;
            OP_OR:   res = a | b;
            OP_NOR:  res = ~(a | b);
            OP_XOR:  res = a ^ b;
            OP_SLT:  res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_SLL:  res = b << ex.shamt;
            OP_SRL:  res = b >> ex.shamt;
            OP_SRA:  res = $signed(b) >>> ex.shamt;
            OP_SLLV: res = b << a[SHAMT_W-1:0];
            OP_SRLV: res = b >> a[SHAMT_W-1:0];
            OP_SRAV: res = $signed(b) >>> a[SHAMT_W-1:0];
            OP_LUI:  res = b << (WIDTH / 2);
            OP_MFHI: res = hi;
            OP_MFLO: res = lo;
            default: res = '0;
        endcase
    end

    assign ex.Ex_ALUout   = res;
    assign ex.Ex_Zero     = (res == '0);
    assign ex.Ex_Sign     = res[WIDTH-1];
    assign ex.Ex_Overflow = ovf;
    assign ex.md_busy     = busy;
    assign ex.md_stall    = busy & ex.Ex_valid & is_hilo(ex.Ex_ALUctr);

endmodule

// File: tb/tb_ex_alu_md.sv
module tb_ex_alu_md;
    import ex_alu_md_pkg::*;

    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_alu_md_if #(.WIDTH(W)) ex ();

    ex_alu_md #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .ex    (ex)
    );

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sbq[$];
    int   errors = 0;
    int   checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_push(input string tag, input logic [31:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sbq.push_back(e);
    endtask

    task automatic sb_pop_check();
        exp_t e;
        checks++;
        assert (sbq.size() != 0) else begin
            errors++;
            $error("FAIL sb_empty observed=no_entry expected=entry");
        end
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            checks--;
            check(e.tag, {32'h0, ex.Ex_ALUout}, {32'h0, e.val});
        end
    endtask

    task automatic drive(input logic v, input logic f, input logic [4:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh);
        ex.Ex_valid  = v;
        ex.Ex_flush  = f;
        ex.Ex_ALUctr = op;
        ex.A         = a;
        ex.B         = b;
        ex.shamt     = sh;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, OP_ADD, 32'h0, 32'h0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one op in the current cycle and compare its combinational result.
    task automatic alu(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] sh, input logic [31:0] exp, input string tag);
        drive(1'b1, 1'b0, op, a, b, sh);
        sb_push(tag, exp);
        @(negedge clk);
        sb_pop_check();
    endtask

    task automatic read_hilo(input logic [31:0] hi_e, input logic [31:0] lo_e, input string tag);
        alu(OP_MFHI, 32'h0, 32'h0, 5'd0, hi_e, {tag, "_hi"});
        tick();
        alu(OP_MFLO, 32'h0, 32'h0, 5'd0, lo_e, {tag, "_lo"});
        tick();
        idle();
    endtask

    // Issue a mult/div, wait (bounded) for md_done, then read back HI/LO from the scoreboard.
    task automatic md_issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] hi_e, input logic [31:0] lo_e, input string tag);
        bit got = 1'b0;
        drive(1'b1, 1'b0, op, a, b, 5'd0);
        sb_push({tag, "_hi"}, hi_e);
        sb_push({tag, "_lo"}, lo_e);
        @(negedge clk);
        tick();
        idle();
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (ex.md_done) begin
                got = 1'b1;
                break;
            end
            tick();
        end
        check({tag, "_done_seen"}, {63'h0, got}, 64'h1);
        tick();
        drive(1'b1, 1'b0, OP_MFHI, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        sb_pop_check();
        tick();
        drive(1'b1, 1'b0, OP_MFLO, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        sb_pop_check();
        tick();
        idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stall_cycles;
        idle();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_busy", {63'h0, ex.md_busy}, 64'h0);
        check("rst_done", {63'h0, ex.md_done}, 64'h0);
        tick();
        read_hilo(32'h0, 32'h0, "rst");

        // Arithmetic, flags and logic.
        alu(OP_ADD, 32'h7FFFFFFF, 32'h1, 5'd0, 32'h80000000, "add_ovf");
        check("add_ovf_flag", {63'h0, ex.Ex_Overflow}, 64'h1);
        check("add_sign", {63'h0, ex.Ex_Sign}, 64'h1);
        tick();
        alu(OP_SUB, 32'h5, 32'h5, 5'd0, 32'h0, "sub_zero");
        check("sub_zero_flag", {63'h0, ex.Ex_Zero}, 64'h1);
        check("sub_zero_ovf", {63'h0, ex.Ex_Overflow}, 64'h0);
        tick();
        alu(OP_SUB, 32'h80000000, 32'h1, 5'd0, 32'h7FFFFFFF, "sub_ovf");
        check("sub_ovf_flag", {63'h0, ex.Ex_Overflow}, 64'h1);
        tick();
        alu(OP_AND, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'h0F000F00, "and");
        tick();
        alu(OP_OR, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'hFF0FFF0F, "or");
        tick();
        alu(OP_NOR, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'h00F000F0, "nor");
        tick();
        alu(OP_XOR, 32'hFF00FF00, 32'h0F0F0F0F, 5'd0, 32'hF00FF00F, "xor");
        check("xor_ovf_zero", {63'h0, ex.Ex_Overflow}, 64'h0);
        tick();
        alu(OP_SLT, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h1, "slt");
        tick();
        alu(OP_SLTU, 32'hFFFFFFFF, 32'h1, 5'd0, 32'h0, "sltu");
        tick();
        alu(OP_SLL, 32'h0, 32'h1, 5'd31, 32'h80000000, "sll");
        tick();
        alu(OP_SRL, 32'h0, 32'hF0000000, 5'd4, 32'h0F000000, "srl");
        tick();
        alu(OP_SRA, 32'h0, 32'hF0000000, 5'd4, 32'hFF000000, "sra");
        tick();
        alu(OP_SRAV, 32'h4, 32'hF0000000, 5'd0, 32'hFF000000, "srav");
        tick();
        alu(OP_SLLV, 32'h21, 32'h3, 5'd0, 32'h6, "sllv_mask");
        tick();
        alu(OP_SRLV, 32'h1F, 32'h80000000, 5'd0, 32'h1, "srlv");
        tick();
        alu(OP_LUI, 32'h0, 32'h1234, 5'd0, 32'h12340000, "lui");
        tick();
        alu(5'h1F, 32'h1234, 32'h5678, 5'd0, 32'h0, "undef");
        check("undef_zero", {63'h0, ex.Ex_Zero}, 64'h1);
        tick();
        idle();

        // MULT -3 x 7 with exact cycle timing.
        drive(1'b1, 1'b0, OP_MULT, 32'hFFFFFFFD, 32'h7, 5'd0);
        sb_push("mult_hi", 32'hFFFFFFFF);
        sb_push("mult_lo", 32'hFFFFFFEB);
        @(negedge clk);
        check("mult_c0_busy", {63'h0, ex.md_busy}, 64'h0);
        check("mult_c0_out", {32'h0, ex.Ex_ALUout}, 64'h0);
        tick();
        idle();
        for (int k = 1; k <= 33; k++) begin
            @(negedge clk);
            check($sformatf("mult_busy_c%0d", k), {63'h0, ex.md_busy}, 64'h1);
            check($sformatf("mult_done_c%0d", k), {63'h0, ex.md_done}, {63'h0, (k == 33)});
            tick();
        end
        drive(1'b1, 1'b0, OP_MFHI, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("mult_c34_busy", {63'h0, ex.md_busy}, 64'h0);
        sb_pop_check();
        tick();
        drive(1'b1, 1'b0, OP_MFLO, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        sb_pop_check();
        tick();
        idle();

        // Divide cases.
        md_issue(OP_DIV,  32'hFFFFFFF9, 32'h2,        32'hFFFFFFFF, 32'hFFFFFFFD, "div_neg");
        md_issue(OP_DIVU, 32'h00001234, 32'h0,        32'h00001234, 32'hFFFFFFFF, "divu_zero");
        md_issue(OP_DIVU, 32'hFFFFFFFF, 32'hA,        32'h00000005, 32'h19999999, "divu_big");
        md_issue(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, "div_min");

        // MULTU with a blocked MTHI and an MFLO held by md_stall.
        drive(1'b1, 1'b0, OP_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd0);
        sb_push("stall_lo", 32'h00000001);
        @(negedge clk);
        tick();
        idle();
        tick();
        drive(1'b1, 1'b0, OP_MTHI, 32'hDEAD, 32'h0, 5'd0);
        @(negedge clk);
        check("mthi_busy_stall", {63'h0, ex.md_stall}, 64'h1);
        tick();
        idle();
        tick();
        tick();
        drive(1'b1, 1'b0, OP_MFLO, 32'h0, 32'h0, 5'd0);
        stall_cycles = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!ex.md_busy) break;
            check("stall_hold", {63'h0, ex.md_stall}, 64'h1);
            stall_cycles++;
            tick();
        end
        check("stall_release", {63'h0, ex.md_stall}, 64'h0);
        check("stall_cycles", stall_cycles, 64'd29);
        sb_pop_check();
        tick();
        read_hilo(32'hFFFFFFFE, 32'h00000001, "multu");

        // MTHI writes; MTLO with flush does not; flushed issue never starts.
        drive(1'b1, 1'b0, OP_MTHI, 32'h0000AAAA, 32'h0, 5'd0);
        @(negedge clk);
        check("mthi_out", {32'h0, ex.Ex_ALUout}, 64'h0);
        tick();
        drive(1'b1, 1'b1, OP_MTLO, 32'h5555, 32'h0, 5'd0);
        tick();
        drive(1'b1, 1'b1, OP_MULT, 32'h2, 32'h3, 5'd0);
        tick();
        idle();
        @(negedge clk);
        check("flush_issue_busy", {63'h0, ex.md_busy}, 64'h0);
        tick();
        read_hilo(32'h0000AAAA, 32'h00000001, "mt");

        // Flush in RUN at cycle 10 of a DIV.
        drive(1'b1, 1'b0, OP_DIV, 32'd100, 32'd7, 5'd0);
        tick();
        idle();
        repeat (9) tick();
        drive(1'b0, 1'b1, OP_ADD, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("flush_run_busy", {63'h0, ex.md_busy}, 64'h1);
        tick();
        idle();
        @(negedge clk);
        check("flush_run_idle", {63'h0, ex.md_busy}, 64'h0);
        tick();
        read_hilo(32'h0000AAAA, 32'h00000001, "flush_run");

        // Flush in DONE (cycle 33) suppresses the write and the pulse.
        drive(1'b1, 1'b0, OP_MULT, 32'h2, 32'h3, 5'd0);
        tick();
        idle();
        repeat (32) tick();
        drive(1'b0, 1'b1, OP_ADD, 32'h0, 32'h0, 5'd0);
        @(negedge clk);
        check("flush_done_busy", {63'h0, ex.md_busy}, 64'h1);
        check("flush_done_pulse", {63'h0, ex.md_done}, 64'h0);
        tick();
        idle();
        @(negedge clk);
        check("flush_done_idle", {63'h0, ex.md_busy}, 64'h0);
        tick();
        read_hilo(32'h0000AAAA, 32'h00000001, "flush_done");

        // Reset mid-operation.
        drive(1'b1, 1'b0, OP_MULT, 32'h5, 32'h5, 5'd0);
        tick();
        idle();
        repeat (4) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_mid_busy", {63'h0, ex.md_busy}, 64'h0);
        tick();
        read_hilo(32'h0, 32'h0, "rst_mid");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
